// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the dmem_responder data-memory target.
// Encodings follow the rv32i load/store funct3 field.
package dmem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } resp_state_e;

    function automatic logic [3:0] be_gen(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_B, OP_BU: be_gen = 4'b0001 << addr_lo;
            OP_H, OP_HU: be_gen = 4'b0011 << {addr_lo[1], 1'b0};
            default:     be_gen = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] op, input logic [31:0] data);
        case (op)
            OP_B, OP_BU: store_rep = {4{data[7:0]}};
            OP_H, OP_HU: store_rep = {2{data[15:0]}};
            default:     store_rep = data;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] addr_lo,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {addr_lo, 3'b000});
        h = 16'(word >> {addr_lo[1], 4'b0000});
        case (op)
            OP_B:    load_ext = {{24{b[7]}}, b};
            OP_BU:   load_ext = {24'h0, b};
            OP_H:    load_ext = {{16{h[15]}}, h};
            OP_HU:   load_ext = {16'h0, h};
            default: load_ext = word;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_B, OP_BU: is_misaligned = 1'b0;
            OP_H, OP_HU: is_misaligned = addr_lo[0];
            default:     is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_B, OP_BU: align_lo = addr_lo;
            OP_H, OP_HU: align_lo = addr_lo & 2'b10;
            default:     align_lo = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word-wide SRAM with per-byte write enables and a registered read port.
module dmem_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the rv32i MEM stage: wait-state FSM, lane steering, load extension.
// Define MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them down.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_op_mem,
    output logic [31:0] mem_rdata_mem,
    output logic        stall_pipl,
    output logic        misaligned_err
);

    localparam int AW = $clog2(DEPTH);

    resp_state_e           state, state_next;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [AW-1:0]         idx_q;
    logic [1:0]            lo_q, lane;
    logic [31:0]           wdata_q, rdata_q, sram_rdata, load_val, sram_wdata;
    logic [2:0]            op_q;
    logic [3:0]            sram_be;
    logic                  we_q, re_q, req, access, blocked, load_done, unused_addr;

    assign req         = mem_read_mem | mem_write_mem;
    assign unused_addr = ^mem_addr_mem[31:AW+2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) cnt <= WAIT_CNT_W'(WAIT_STATES);
            else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    // Request fields need no reset: they are only consumed after being captured here.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            idx_q   <= mem_addr_mem[AW+1:2];
            lo_q    <= mem_addr_mem[1:0];
            wdata_q <= mem_wdata_mem;
            op_q    <= mem_op_mem;
            we_q    <= mem_write_mem;
            re_q    <= mem_read_mem & ~mem_write_mem;
        end
    end

    always_comb begin
        state_next = state;
        stall_pipl = 1'b0;
        case (state)
            IDLE: if (req) begin
                stall_pipl = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                stall_pipl = 1'b1;
                if (cnt == '0) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!reset_n) stall_pipl = 1'b0;
    end

    assign access = (state == BUSY) && (cnt == '0);

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    assign blocked = is_misaligned(op_q, lo_q);
    assign lane    = lo_q;

    always_ff @(posedge clk) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= access & blocked;
    end

    assign misaligned_err = err_q;
`else
    assign blocked        = 1'b0;
    assign lane           = align_lo(op_q, lo_q);
    assign misaligned_err = 1'b0;
`endif

    assign sram_be    = be_gen(op_q, lane);
    assign sram_wdata = store_rep(op_q, wdata_q);

    // Gating with reset_n drops a write whose access edge coincides with reset.
    dmem_sram #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    (access & reset_n),
        .we    (we_q & ~blocked),
        .be    (sram_be),
        .addr  (idx_q),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    assign load_val  = load_ext(op_q, lane, sram_rdata);
    assign load_done = (state == DONE) && re_q && !blocked && reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n)       rdata_q <= '0;
        else if (load_done) rdata_q <= load_val;
    end

    // Registered SRAM read lands in DONE, so the fresh value bypasses the holding register.
    assign mem_rdata_mem = load_done ? load_val : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (0 and 3 wait states) against a byte-level memory model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] addr, wdata;
    logic        rd, wr;
    logic [2:0]  op;
    int          sel;

    logic        rd0, wr0, rd3, wr3;
    logic [31:0] rdata0, rdata3;
    logic        stall0, stall3, err0, err3;

    assign rd0 = (sel == 0) & rd;
    assign wr0 = (sel == 0) & wr;
    assign rd3 = (sel == 1) & rd;
    assign wr3 = (sel == 1) & wr;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset_n(reset_n), .mem_addr_mem(addr), .mem_wdata_mem(wdata),
        .mem_write_mem(wr0), .mem_read_mem(rd0), .mem_op_mem(op),
        .mem_rdata_mem(rdata0), .stall_pipl(stall0), .misaligned_err(err0)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .reset_n(reset_n), .mem_addr_mem(addr), .mem_wdata_mem(wdata),
        .mem_write_mem(wr3), .mem_read_mem(rd3), .mem_op_mem(op),
        .mem_rdata_mem(rdata3), .stall_pipl(stall3), .misaligned_err(err3)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_q [$];

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    function automatic logic obs_stall();
        return (sel == 0) ? stall0 : stall3;
    endfunction

    function automatic logic [31:0] obs_rdata();
        return (sel == 0) ? rdata0 : rdata3;
    endfunction

    function automatic logic obs_err();
        return (sel == 0) ? err0 : err3;
    endfunction

    // Reference: byte-granular access with size from funct3, alignment by modulo arithmetic.
    function automatic void model_access(input int s, input logic r, input logic w, input logic [2:0] o,
                                         input logic [31:0] a, input logic [31:0] d, output logic exp_err);
        int size, lo, idx;
        logic [31:0] word, val;
        size    = (o == 3'b000 || o == 3'b100) ? 1 : (o == 3'b001 || o == 3'b101) ? 2 : 4;
        lo      = int'(a % 4);
        idx     = int'((a / 4) % DEPTH);
        exp_err = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((lo % size) != 0) begin
            exp_err = 1'b1;
            return;
        end
`endif
        lo   = lo - (lo % size);
        word = model_mem[s][idx];
        if (w) begin
            for (int k = 0; k < size; k++) word[8*(lo+k) +: 8] = d[8*k +: 8];
            model_mem[s][idx] = word;
        end else if (r) begin
            val = 32'h0;
            for (int k = 0; k < size; k++) val[8*k +: 8] = word[8*(lo+k) +: 8];
            if (o == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
            if (o == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
            exp_rdata[s] = val;
        end
    endfunction

    // Starts right after a rising edge; returns right after the edge that ends DONE.
    task automatic do_access(input logic r, input logic w, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] d, input string name);
        int n;
        logic exp_err;
        logic [31:0] exp_rd, got_rd;
        logic got_err;
        rd = r; wr = w; op = o; addr = a; wdata = d;
        n = 0;
        @(negedge clk);
        while (obs_stall() === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        got_rd  = obs_rdata();
        got_err = obs_err();
        model_access(sel, r, w, o, a, d, exp_err);
        exp_q.push_back(exp_rdata[sel]);
        exp_rd = exp_q.pop_front();
        total++;
        if (n !== ws_of(sel) + 2) begin
            bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, n, ws_of(sel) + 2);
        end
        total++;
        if (got_rd !== exp_rd) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd);
        end
        total++;
        if (got_err !== exp_err) begin
            bad++;
            $display("FAIL %s misaligned_err: got %b want %b", name, got_err, exp_err);
        end
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0; rd = 1'b1; wr = 1'b0; op = 3'b010; addr = '0; wdata = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({stall0, stall3} !== 2'b00) begin
            bad++;
            $display("FAIL reset_stall: got %b want 00", {stall0, stall3});
        end
        total++;
        if ({rdata0, rdata3} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h %h want 0", rdata0, rdata3);
        end
        total++;
        if ({err0, err3} !== 2'b00) begin
            bad++;
            $display("FAIL reset_err: got %b want 00", {err0, err3});
        end
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        @(posedge clk);
        #1;
        rd = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs_stall() !== 1'b0) begin
            bad++;
            $display("FAIL idle_stall: got %b want 0", obs_stall());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word();
        sel = 0;
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_0x10");
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_0x10");
    endtask

    task automatic test_byte();
        sel = 0;
        do_access(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080, "sb_0x13");
        do_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, "lb_0x13");
        do_access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, "lbu_0x13");
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_after_sb");
    endtask

    task automatic test_half();
        sel = 0;
        do_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_8001, "sh_0x22");
        do_access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, "lh_0x22");
        do_access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, "lhu_0x22");
    endtask

    task automatic test_wait_states();
        sel = 1;
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h0BAD_F00D, "ws3_sw");
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "ws3_lw");
    endtask

    // Request held continuously: stall pattern must repeat WS+2 high, 1 low.
    task automatic test_back_to_back();
        int period;
        logic exp_stall, exp_err;
        sel = 1;
        period = ws_of(sel) + 3;
        rd = 1'b1; wr = 1'b0; op = 3'b010; addr = 32'h10; wdata = '0;
        for (int cyc = 0; cyc < 3 * period; cyc++) begin
            @(negedge clk);
            exp_stall = ((cyc % period) != period - 1);
            total++;
            if (obs_stall() !== exp_stall) begin
                bad++;
                $display("FAIL b2b_stall cycle %0d: got %b want %b", cyc, obs_stall(), exp_stall);
            end
            if (!exp_stall) begin
                model_access(sel, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, exp_err);
                total++;
                if (obs_rdata() !== exp_rdata[sel]) begin
                    bad++;
                    $display("FAIL b2b_rdata cycle %0d: got %h want %h", cyc, obs_rdata(), exp_rdata[sel]);
                end
            end
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1;
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, "prior_sw_0x40");
        rd = 1'b0; wr = 1'b1; op = 3'b010; addr = 32'h40; wdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if (obs_stall() !== 1'b1) begin
            bad++;
            $display("FAIL mid_accept_stall: got %b want 1", obs_stall());
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (obs_stall() !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_stall: got %b want 0", obs_stall());
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
        reset_n = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        @(negedge clk);
        total++;
        if (obs_stall() !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_stall: got %b want 0", obs_stall());
        end
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, "lw_after_dropped_sw");
    endtask

    task automatic test_misaligned();
        sel = 0;
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h1122_3344, "sw_0x40");
        do_access(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, "lb_0x10");
        do_access(1'b1, 1'b0, 3'b010, 32'h41, 32'h0, "lw_0x41");
        do_access(1'b1, 1'b0, 3'b001, 32'h43, 32'h0, "lh_0x43");
        do_access(1'b0, 1'b1, 3'b010, 32'h42, 32'hAAAA_5555, "sw_0x42");
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, "lw_0x40_after");
    endtask

    task automatic test_random();
        logic r, w;
        logic [2:0] o;
        logic [31:0] a;
        int kind;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 16; i++)
                do_access(1'b0, 1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom(), "rand_init");
            for (int i = 0; i < 40; i++) begin
                kind = $urandom_range(0, 2);
                r = (kind != 1);
                w = (kind != 0);
                o = 3'($urandom_range(0, 7));
                a = ($urandom() & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
                do_access(r, w, o, a, $urandom(), "rand_op");
            end
        end
    endtask

    initial begin
        rd = 1'b0; wr = 1'b0; op = '0; addr = '0; wdata = '0; sel = 0; reset_n = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        test_misaligned();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
